// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory delay arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which requester owns the in-flight transaction
//   LFSR_SEED   : reset value of the optional random-delay LFSR
//   lfsr_next   : one step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } arb_owner_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/mem_delay_cnt.sv
// Wait-cycle down-counter for the arbiter.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; held at zero, never wraps
//   value      : current count
//   zero       : registered flag, high when value == 0
module mem_delay_cnt #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);

    // Count register with a zero flag tracked alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            value <= load_val;
            zero  <= (load_val == '0);
        end else if (dec && !zero) begin
            value <= value - W'(1);
            zero  <= (value == W'(1));
        end
    end

endmodule

// File: rtl/mem_delay_arbiter.sv
// Shares one single-port memory between IFU fetches and LSU loads/stores,
// inserting a programmable number of wait cycles per transaction.
//   cfg_delay           : wait cycles per transaction, sampled at accept
//   ifu_req_* / ifu_rsp_*: IFU read request handshake and one-cycle response
//   lsu_req_* / lsu_rsp_*: LSU load/store request handshake and one-cycle response
//   mem_*               : single-cycle memory access strobe and latched fields
// Latency: accept in cycle T -> mem_en in T+1+d -> rsp_valid in T+2+d.
// Optional macro MEM_DELAY_RAND_EN: delay = lfsr[DLY_W-1:0] & cfg_delay,
// with an 8-bit LFSR seeded at reset and advancing every cycle.
module mem_delay_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DLY_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DLY_W-1:0]    cfg_delay,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_req_wen,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                mem_en,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t       state, state_next;
    arb_owner_t       owner, last_grant;
    logic             grant_ifu_c, grant_lsu_c, accept_c;
    logic [DLY_W-1:0] delay_c, cnt_load_val_c, cnt_value;
    logic             cnt_load_c, cnt_dec_c, cnt_zero;

    // Round-robin grant, only offered while idle; IFU wins when LSU went last
    assign grant_ifu_c = (state == IDLE) && ifu_req_valid &&
                         (!lsu_req_valid || (last_grant == OWN_LSU));
    assign grant_lsu_c = (state == IDLE) && lsu_req_valid &&
                         (!ifu_req_valid || (last_grant == OWN_IFU));
    assign accept_c      = grant_ifu_c || grant_lsu_c;
    assign ifu_req_ready = grant_ifu_c;
    assign lsu_req_ready = grant_lsu_c;

`ifdef MEM_DELAY_RAND_EN
    logic [7:0] lfsr;

    // Free-running LFSR used to randomise the per-transaction delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign delay_c = lfsr[DLY_W-1:0] & cfg_delay;
`else
    assign delay_c = cfg_delay;
`endif

    mem_delay_cnt #(
        .W (DLY_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_c),
        .load_val (cnt_load_val_c),
        .dec      (cnt_dec_c),
        .value    (cnt_value),
        .zero     (cnt_zero)
    );

    // Next state; WAIT spans exactly d cycles, so d=0 goes straight to ACCESS
    always_comb begin
        state_next     = state;
        cnt_load_c     = 1'b0;
        cnt_load_val_c = '0;
        cnt_dec_c      = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    cnt_load_c = 1'b1;
                    if (delay_c == '0) begin
                        state_next = ACCESS;
                    end else begin
                        state_next     = WAIT;
                        cnt_load_val_c = delay_c - DLY_W'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    state_next = ACCESS;
                end else begin
                    cnt_dec_c = (cnt_value != '0);
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, latched request fields and registered responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= OWN_IFU;
            last_grant    <= OWN_LSU;
            mem_en        <= 1'b0;
            mem_wen       <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_data  <= '0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_data  <= '0;
        end else begin
            state  <= state_next;
            mem_en <= (state_next == ACCESS);
            if (accept_c) begin
                owner      <= grant_lsu_c ? OWN_LSU : OWN_IFU;
                last_grant <= grant_lsu_c ? OWN_LSU : OWN_IFU;
                mem_wen    <= grant_lsu_c && lsu_req_wen;
                mem_addr   <= grant_lsu_c ? lsu_req_addr : ifu_req_addr;
                mem_wdata  <= grant_lsu_c ? lsu_req_wdata : '0;
                mem_wmask  <= grant_lsu_c ? lsu_req_wmask : '0;
            end
            ifu_rsp_valid <= (state == ACCESS) && (owner == OWN_IFU);
            lsu_rsp_valid <= (state == ACCESS) && (owner == OWN_LSU);
            if (state == ACCESS) begin
                if (owner == OWN_IFU) begin
                    ifu_rsp_data <= mem_rdata;
                end else begin
                    lsu_rsp_data <= mem_wen ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule
